dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder: the far end of the core's load/store data path that produces the load word the writeback path consumes.
- Accepts one request at a time from the core's LSU over a valid/ready request channel.
- Performs the word access against internal storage after a configurable number of wait states.
- Returns read data or completion on a valid/ready response channel.
- Used to run the core against non-zero-latency memory in simulation and FPGA builds.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words of storage. Power of two, 16 to 65536.
- WAIT_CYCLES, 2: wait states between request accept and data access. Range 0 to 15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0. Must be DEPTH_WORDS*4 aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, already lane-aligned by the LSU.
- req_be  in  4  byte enables. Bit i enables byte lane i.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load data, full word. Lane selection and extension are done by the core.
- rsp_err  out  1  access fault.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - req_ready=0 while rst_n=0, and 1 in the first cycle after release.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, wait counter=0.
  - Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch we/addr/wdata/be and load counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle. When counter==1, the next state is RESP.
- Access (commit):
  - Performed on the clock edge that enters RESP.
  - Store: writes only the enabled lanes and sets rsp_rdata=0.
  - Load: rsp_rdata = mem[idx].
  - Latency: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge.
- Index and fault rules:
  - idx = (req_addr-BASE_ADDR)>>2, computed on 32-bit unsigned wrap-around arithmetic.
  - Fault if req_addr[1:0]!=0, or idx>=DEPTH_WORDS, or req_be==0.
  - On fault: rsp_err=1, rsp_rdata=0, and storage is unmodified.
  - req_be is ignored for loads except for the be==0 fault check.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On that handshake: next state IDLE, rsp_valid=0, and rsp_err and rsp_rdata return to 0.
  - req_ready=0 throughout RESP. A new request is accepted earliest in the cycle after the response handshake.
- Ordering: at most one outstanding request. req_* inputs are ignored outside IDLE.
- Backpressure: rsp_ready held low for any number of cycles keeps RESP and the outputs unchanged.
- Reset mid-operation: asserting rst_n=0 in WAIT aborts the request. A store not yet committed never writes. A store already committed (state in RESP) persists.
- Counter width is 4 bits. No wrap: it is loaded only in IDLE and stops at 1.

Decomposition:
- Package dmem_pkg:
  - State enum {IDLE, WAIT, RESP}.
  - Lane-count constant (4) and word-offset constant (2).
  - Function that builds a 32-bit lane write mask from be.
- Sub-module dmem_array: single-port synchronous word RAM with per-byte write enable. One read or write per cycle.
  - Ports: clk, en, we, be, addr, wdata, rdata.
  - No reset; it infers block RAM.
- dmem_responder holds the FSM, counter, fault decode and output registers.
- Read timing: the array read is launched on the final WAIT cycle, or the accept cycle when WAIT_CYCLES=0, so the result registers on the RESP-entry edge.

Test Plan:
- Reset release, idle: req_ready=1 and rsp_valid=0 in the first cycle after rst_n rises; outputs stay 0 with req_valid=0.
- Store then load, WAIT_CYCLES=2:
  - Store addr 0x10, wdata 0xDEADBEEF, be=4'hF → rsp_valid exactly 3 cycles after accept, rsp_err=0, rsp_rdata=0.
  - Load 0x10 → rsp_rdata=0xDEADBEEF.
- Byte-lane store:
  - Start from word 0x10 = 0xDEADBEEF.
  - Store 0x10, wdata 0x0000AA00, be=4'b0010 → load returns 0xDEADAAEF.
- Faults, each giving rsp_err=1 and rsp_rdata=0:
  - Load 0x11 (misaligned).
  - Load BASE_ADDR+DEPTH_WORDS*4 (out of range).
  - Store with be=0. A follow-up load shows storage unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_rdata and rsp_err stay constant and req_ready stays 0. Releasing rsp_ready gives req_ready=1 the next cycle.
- Reset in WAIT:
  - Store 0x55555555 to 0x20 (prior value 0x12345678) and assert rst_n=0 one cycle after accept, with WAIT_CYCLES=2.
  - After release, load 0x20 → 0x12345678 and no spurious rsp_valid.
  - Repeat with WAIT_CYCLES=0 to check the 1-cycle latency.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t    : responder FSM states
//   LANES      : byte lanes per 32-bit word
//   WORD_OFS   : byte-address bits below the word index
//   lane_mask(): expands byte enables into a 32-bit bit mask
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LANES    = 4;
  localparam int WORD_OFS = 2;

  function automatic logic [31:0] lane_mask(input logic [LANES-1:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response channel between the core's LSU (master) and the
// data-memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata/req_be    : lane-aligned store data and byte enables
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : full load word (0 for stores and faults)
//   rsp_err             : access fault
interface dmem_if;

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_we;
  logic [31:0]                req_addr;
  logic [31:0]                req_wdata;
  logic [dmem_pkg::LANES-1:0] req_be;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [31:0]                rsp_rdata;
  logic                       rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enable.
// One read or one write per enabled cycle; read data is registered.
// No reset so the storage maps onto block RAM.
//   clk   : clock
//   en    : access enable
//   we    : 1 = write enabled lanes, 0 = read word into rdata
//   be    : byte-lane enables for writes
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (holds until the next read)
module dmem_array import dmem_pkg::*; #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [LANES-1:0] be,
  input  logic [AW-1:0]    addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] wmask;

  assign wmask = lane_mask(be);

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits
// WAIT_CYCLES, performs the word access on the edge that enters RESP and
// holds the response until the core takes it.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : dmem_if slave port (request and response channels)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request; req_ready=1
// WAIT  | request latched, counting down the wait states
// RESP  | access done, response held until rsp_valid&&rsp_ready
module dmem_responder import dmem_pkg::*; #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic             accept;
  logic             launch;

  logic             lat_we;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic [LANES-1:0] lat_be;

  logic             acc_we;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [LANES-1:0] acc_be;
  logic [31:0]      acc_ofs;
  logic [31:0]      acc_idx;
  logic             acc_fault;

  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic             rd_sel;
  logic [31:0]      arr_rdata;

  assign accept = bus.req_valid && bus.req_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT: if (cnt == 4'd1) state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. req_ready is gated by rst_n so it reads 0 during reset
  // even though the state register already sits in IDLE. launch marks the
  // cycle whose closing edge performs the access (and enters RESP).
  always_comb begin
    bus.req_ready = 1'b0;
    launch        = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = rst_n;
        launch        = bus.req_valid && rst_n && (WAIT_CYCLES == 0);
      end
      WAIT:    launch = (cnt == 4'd1);
      default: ;
    endcase
  end

  // With no wait states the access launches in the accept cycle, so the
  // operands come straight off the bus; otherwise from the latched copy.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_be    = bus.req_be;
    end else begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
    end
  end

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of
  // range and fault.
  assign acc_ofs   = acc_addr - BASE_ADDR;
  assign acc_idx   = acc_ofs >> WORD_OFS;
  assign acc_fault = (acc_addr[WORD_OFS-1:0] != '0)
                  || (acc_idx >= 32'(DEPTH_WORDS))
                  || (acc_be == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 4'd0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_be      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_sel      <= 1'b0;
    end else begin
      if (accept) begin
        lat_we    <= bus.req_we;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        lat_be    <= bus.req_be;
        cnt       <= WAIT_LOAD;
      end else if (state == WAIT && cnt > 4'd1) begin
        cnt <= cnt - 4'd1;
      end

      if (launch) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= acc_fault;
        rd_sel      <= !acc_we && !acc_fault;
      end else if (state == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
        rsp_err_q   <= 1'b0;
        rd_sel      <= 1'b0;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .en    (launch && !acc_fault),
    .we    (acc_we),
    .be    (acc_be),
    .addr  (acc_idx[AW-1:0]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  // The array's read register holds through RESP because the array is only
  // enabled on launch cycles; rd_sel forces 0 for stores, faults and idle.
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rd_sel ? arr_rdata : '0;

endmodule
